// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream path.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: default data width, skid depth, skid occupancy type and helper.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int SKID_DEPTH     = 2;

  // Skid buffer fill level; 3 is never reached.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_cnt_t;

  // Words held after the coming edge: current fill plus a landing word
  // minus a word leaving downstream.
  function automatic logic [2:0] skid_occupancy(input skid_cnt_t cnt,
                                                input logic      push,
                                                input logic      pop);
    return 3'(cnt) + 3'(push) - 3'(pop);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready skid buffer with a one-bit read credit.
// Latency: a word pushed at an edge is on out_dat the next cycle.
// Backpressure: in_vld has no ready; the source must only push when credit was 1.
// Ports: clk, rst_n (async active-low), flush (sync clear), in_vld/in_dat (push),
//        out_vld/out_rdy/out_dat (stream), credit (room for a word issued now).
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  credit
);

  skid_cnt_t             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;
  logic [2:0]            occ;

  assign out_vld = (cnt_q != SKID_EMPTY);
  assign out_dat = head_q;
  assign pop     = out_vld & out_rdy;

  // Credit looks at the fill level after this edge, so a word leaving this
  // cycle frees a slot for a read issued in the same cycle.
  assign occ    = skid_occupancy(cnt_q, in_vld, pop);
  assign credit = (occ < 3'(SKID_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= SKID_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Head only moves on a pop or when the buffer is empty, which keeps
  // out_dat stable while out_vld is held against out_rdy=0.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      // Data registers keep stale contents; they are hidden by out_vld=0.
      cnt_d = SKID_EMPTY;
    end else begin
      case (cnt_q)
        SKID_EMPTY: begin
          if (in_vld) begin
            head_d = in_dat;
            cnt_d  = SKID_ONE;
          end
        end
        SKID_ONE: begin
          case ({in_vld, pop})
            2'b11: head_d = in_dat;
            2'b10: begin
              tail_d = in_dat;
              cnt_d  = SKID_FULL;
            end
            2'b01: cnt_d = SKID_EMPTY;
            default: ;
          endcase
        end
        SKID_FULL: begin
          // A push without a pop cannot happen here: credit was 0.
          if (pop) begin
            head_d = tail_q;
            if (in_vld) begin
              tail_d = in_dat;
            end else begin
              cnt_d = SKID_ONE;
            end
          end
        end
        default: cnt_d = SKID_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO, re-presenting words as a valid/ready stream.
// Latency: 2 cycles from a non-empty FIFO to m_valid (rd_en cycle, capture cycle); 1 word/cycle sustained.
// Backpressure: at most 2 words are read ahead while m_ready=0, then fifo_rd_en stays low.
// Ports: clk, rst_n (async active-low), fifo_empty/fifo_dout/fifo_rd_en (FIFO side),
//        flush (sync clear of buffered and in-flight words), m_valid/m_ready/m_data (stream),
//        words_out (wrapping count of accepted stream words).
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic                 inflight_q;
  logic                 credit;
  logic                 pop;
  logic [CNT_WIDTH-1:0] words_q;

  assign pop       = m_valid & m_ready;
  assign words_out = words_q;

  // The in-flight word already owns a slot via the credit calculation, so
  // a fresh read is only issued when one more word is guaranteed to fit.
  // rst_n gates the request so nothing is popped while the block is held in reset.
  assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      inflight_q <= flush ? 1'b0 : fifo_rd_en;
      // A pop coincident with flush still left the block, so it is counted.
      words_q    <= words_q + CNT_WIDTH'(pop);
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_vld  (inflight_q),
    .in_dat  (fifo_dout),
    .out_vld (m_valid),
    .out_rdy (m_ready),
    .out_dat (m_data),
    .credit  (credit)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO and a scoreboard queue.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] words_out;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .words_out  (words_out)
  );

  // Behavioural FIFO: pop on rd_en & !empty, data one cycle later; reset drops contents.
  logic [DW-1:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_push(input logic [DW-1:0] d, input bit expect_out);
    fmem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
    if (expect_out) exp_q.push_back(d);
  endtask

  // Monitor: per-cycle protocol checks and scoreboard pops, sampled at negedge.
  int cyc = 0;
  int rd_cnt = 0, pop_cnt = 0;
  int rd_first = -1, rd_last = -1, pop_first = -1, pop_last = -1;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (fifo_empty) chk("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
      if (hold_prev) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (fifo_rd_en && !fifo_empty) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (pop_first < 0) pop_first = cyc;
        pop_last = cyc;
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      hold_prev = m_valid && !m_ready && !flush;
      prev_data = m_data;
    end
  end

  task automatic mark();
    rd_cnt = 0; pop_cnt = 0;
    rd_first = -1; rd_last = -1; pop_first = -1; pop_last = -1;
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 32'(pop_cnt), 32'(target));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_words", 32'(words_out), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Empty FIFO for 20 cycles
    mark();
    repeat (20) @(posedge clk);
    #1;
    chk("empty_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("empty_valid", 32'(m_valid), 32'd0);
    chk("empty_words", 32'(words_out), 32'd0);

    // Streaming with m_ready=1
    m_ready = 1'b1;
    mark();
    fifo_push(8'hA1, 1); fifo_push(8'hB2, 1); fifo_push(8'hC3, 1); fifo_push(8'hD4, 1);
    wait_pops(4, 20, "t1_pops");
    #1;
    chk("t1_words", 32'(words_out), 32'd4);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("t1_rd_span", 32'(rd_last - rd_first), 32'd3);
    chk("t1_latency", 32'(pop_first - rd_first), 32'd2);
    chk("t1_pop_span", 32'(pop_last - pop_first), 32'd3);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: at most two reads ahead
    m_ready = 1'b0;
    mark();
    fifo_push(8'hA1, 1); fifo_push(8'hB2, 1); fifo_push(8'hC3, 1); fifo_push(8'hD4, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd2);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_data", 32'(m_data), 32'hA1);
    m_ready = 1'b1;
    wait_pops(4, 20, "t2_pops");
    #1;
    chk("t2_words", 32'(words_out), 32'd8);
    chk("t2_rd_total", 32'(rd_cnt), 32'd4);

    // Toggling ready, eight words
    mark();
    for (int i = 0; i < 8; i++) fifo_push(8'(i), 1);
    for (int i = 0; i < 60 && pop_cnt < 8; i++) begin
      m_ready = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    chk("t3_pops", 32'(pop_cnt), 32'd8);
    chk("t3_words", 32'(words_out), 32'd16);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with a word in flight
    m_ready = 1'b0;
    mark();
    fifo_push(8'hA1, 1); fifo_push(8'hB2, 0); fifo_push(8'hC3, 0); fifo_push(8'hD4, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_rd_cnt2", 32'(rd_cnt), 32'd2);
    chk("t5_head", 32'(m_data), 32'hA1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("t5_third_rd", 32'(fifo_rd_en), 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t5_rd_cnt3", 32'(rd_cnt), 32'd3);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t5_valid_after_flush", 32'(m_valid), 32'd0);
    chk("t5_words_kept", 32'(words_out), 32'd17);
    exp_q.push_back(8'hD4);
    m_ready = 1'b1;
    wait_pops(2, 20, "t5_pops");
    #1;
    chk("t5_words", 32'(words_out), 32'd18);
    chk("t5_rd_total", 32'(rd_cnt), 32'd4);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-stream
    mark();
    for (int i = 0; i < 8; i++) fifo_push(8'h30 + 8'(i), 1);
    wait_pops(3, 20, "t6_pre_pops");
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t6_rst_words", 32'(words_out), 32'd0);
    chk("t6_rst_data", 32'(m_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mark();
    fifo_push(8'hE5, 1);
    wait_pops(1, 20, "t6_pops");
    #1;
    chk("t6_words", 32'(words_out), 32'd1);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
